aes_ctr_engine: RTL
===================

Name: aes_ctr_engine

Overview:
- CTR-mode streaming front end for a fixed-latency pipelined AES encipher core (round key expansion plus LAT-stage encipher chain).
- Generates counter blocks and issues one per accepted plaintext beat to the core.
- Buffers plaintext until the matching keystream returns, then outputs XORed ciphertext (CTR decrypt is identical) on a valid/ready stream with backpressure.
- Adds flow control, counter wrap, and post-reset core flush, none of which the bare pipelined core has.

Parameters:
- CORE_LAT, 11: cycles from core_valid_o high to matching core_valid_i high; fixed, results return in order.
- DEPTH, 16: plaintext and keystream FIFO depth, and the maximum number of blocks in flight. Must be a power of 2 and at least 2.
- CTR_W, 32: low counter bits incremented per block. Upper 128-CTR_W bits stay constant.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- key_ready  in  1  round keys valid (from key schedule)
- iv_load  in  1  load initial counter block
- iv  in  128  initial counter block
- in_valid  in  1  plaintext beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_data  in  128  plaintext/ciphertext block
- in_last  in  1  final beat of message
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  128  in_data XOR E(K,ctr)
- out_last  out  1  final result of message
- core_valid_o  out  1  issue strobe to core
- core_block_o  out  128  counter block to core
- core_valid_i  in  1  keystream strobe from core
- core_block_i  in  128  keystream block
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error
- blk_count  out  32  blocks output since last iv_load (wraps)

Behaviour:
- States: FLUSH, IDLE, RUN, DRAIN.
- reset → FLUSH. Reset values: all FIFOs empty, inflight=0, ctr=0, core_valid_o=0, core_block_o=0, out_valid=0, in_ready=0, err=0, blk_count=0.
- FLUSH:
  - Counts CORE_LAT+1 cycles, then → IDLE.
  - core_valid_i is ignored (dropped) throughout FLUSH, so stale results from before a mid-operation reset are discarded.
  - busy=1 in FLUSH.
- IDLE:
  - iv_load&&key_ready: ctr<=iv, blk_count<=0, → RUN.
  - iv_load without key_ready is ignored.
  - iv_load in RUN or DRAIN is ignored.
- RUN:
  - in_ready = (inflight<DEPTH) && key_ready.
  - On accept:
    - in_data and in_last push into the plaintext FIFO.
    - Next cycle: core_valid_o=1 for exactly one cycle, with core_block_o=ctr.
    - ctr[CTR_W-1:0] increments mod 2^CTR_W; ctr[127:CTR_W] is unchanged (wrap from all-ones to 0 is silent).
  - Accept with in_last=1 → DRAIN.
- DRAIN:
  - in_ready=0.
  - When inflight reaches 0 (last beat popped) → IDLE.
- inflight:
  - +1 on accept, −1 on output pop, net 0 when both happen in the same cycle.
  - Range 0..DEPTH.
- Keystream path:
  - core_valid_i (outside FLUSH) pushes core_block_i into the keystream FIFO.
  - If the keystream FIFO is full, or keystream count would exceed plaintext count, set err=1 and drop the beat.
- Output:
  - out_valid = both FIFOs non-empty.
  - out_data = pt_head ^ ks_head; out_last = pt_head's last flag. Both are combinational from FIFO heads.
  - Pop both FIFOs when out_valid&&out_ready; blk_count+1 on each pop.
  - out_valid/out_data hold stable while out_ready=0.
- Latency: accept at cycle t → core_valid_o at t+1 → core_valid_i at t+1+CORE_LAT → out_valid earliest at t+2+CORE_LAT.
- Throughput: 1 block/cycle sustained with out_ready=1.
- With out_ready=0, at most DEPTH accepts occur, then in_ready=0.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle are both honoured.
  - reset overrides all other inputs.
  - err clears only on reset.

Test Plan:
1. SP800-38A F.5.1 vectors: key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 4 plaintext beats 6bc1bee22e409f96e93d7e117393172a… with the last beat flagged → out_data 874d6191b620e3261bef6864990db6ce, 9806f66b7991fb42…, 5ae4df3edbd5d35e…, 1e031dda2fbe03d1…; out_last on the 4th beat; state returns to IDLE; blk_count=4.
2. Latency check, CORE_LAT=11: single beat accepted at cycle 10 → core_valid_o at 11, out_valid first at 23.
3. Backpressure: out_ready=0 while offering 20 beats → exactly 16 accepted, then in_ready=0. Raise out_ready → all 20 outputs emerge in order with no loss or duplication.
4. Counter wrap: iv=…_FFFFFFFE with CTR_W=32, 3 beats → core_block_o low 32 bits FFFFFFFE, FFFFFFFF, 00000000; upper 96 bits unchanged.
5. Reset mid-operation: assert reset with 5 blocks in flight, and the core model continues returning them → those 5 are dropped during FLUSH; err stays 0; no out_valid. A new message after IDLE is correct.
6. Protocol error: inject a spurious core_valid_i while inflight=0 in RUN → err=1 sticky, keystream FIFO unchanged, out_valid stays 0.

Source files
------------

// File: rtl/aes_ctr_engine.sv
// rtl/aes_ctr_engine.sv - CTR-mode streaming front end for a fixed-latency pipelined AES core
module aes_ctr_engine #(
    parameter int CORE_LAT = 11,
    parameter int DEPTH    = 16,
    parameter int CTR_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_ready,
    input  logic         iv_load,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         core_valid_o,
    output logic [127:0] core_block_o,
    input  logic         core_valid_i,
    input  logic [127:0] core_block_i,
    output logic         busy,
    output logic         err,
    output logic [31:0]  blk_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(CORE_LAT + 2);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state, state_next;
    logic [FW-1:0]   flush_cnt;
    logic [127:0]    ctr;

    logic [127:0]    pt_mem [DEPTH];
    logic [DEPTH-1:0] pt_last_mem;
    logic [127:0]    ks_mem [DEPTH];
    logic [AW-1:0]   pt_wp, pt_rp, ks_wp, ks_rp;
    logic [CW-1:0]   inflight, inflight_next, ks_cnt;

    logic accept, pop, load_iv, ks_in, ks_bad, ks_push;

    assign in_ready  = (state == S_RUN) && (inflight < CW'(DEPTH)) && key_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (inflight != '0) && (ks_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = pt_mem[pt_rp] ^ ks_mem[ks_rp];
    assign out_last  = pt_last_mem[pt_rp];
    assign load_iv   = (state == S_IDLE) && iv_load && key_ready;
    assign busy      = (state != S_IDLE);

    // A keystream beat with no waiting plaintext cannot belong to any issued block.
    assign ks_in   = core_valid_i && (state != S_FLUSH);
    assign ks_bad  = ks_in && ((ks_cnt == CW'(DEPTH)) || (ks_cnt >= inflight));
    assign ks_push = ks_in && !ks_bad;

    assign inflight_next = inflight + CW'(accept) - CW'(pop);

    always_comb begin
        state_next = state;
        case (state)
            S_FLUSH: if (flush_cnt == FW'(CORE_LAT)) state_next = S_IDLE;
            S_IDLE:  if (load_iv) state_next = S_RUN;
            S_RUN:   if (accept && in_last) state_next = S_DRAIN;
            S_DRAIN: if (inflight_next == '0) state_next = S_IDLE;
            default: state_next = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FLUSH;
            flush_cnt    <= '0;
            ctr          <= '0;
            core_valid_o <= 1'b0;
            core_block_o <= '0;
            pt_wp        <= '0;
            pt_rp        <= '0;
            ks_wp        <= '0;
            ks_rp        <= '0;
            inflight     <= '0;
            ks_cnt       <= '0;
            err          <= 1'b0;
            blk_count    <= '0;
        end else begin
            state        <= state_next;
            flush_cnt    <= (state == S_FLUSH) ? flush_cnt + FW'(1) : '0;
            core_valid_o <= accept;
            if (accept) begin
                core_block_o <= ctr;
                ctr          <= {ctr[127:CTR_W], ctr[CTR_W-1:0] + CTR_W'(1)};
                pt_wp        <= pt_wp + AW'(1);
            end else if (load_iv) begin
                ctr <= iv;
            end
            if (ks_push) ks_wp <= ks_wp + AW'(1);
            if (pop) begin
                pt_rp <= pt_rp + AW'(1);
                ks_rp <= ks_rp + AW'(1);
            end
            inflight <= inflight_next;
            ks_cnt   <= ks_cnt + CW'(ks_push) - CW'(pop);
            if (ks_bad) err <= 1'b1;
            if (load_iv)  blk_count <= '0;
            else if (pop) blk_count <= blk_count + 32'd1;
        end
    end

    // Storage only; occupancy is tracked by the pointers and counts above.
    always_ff @(posedge clk) begin
        if (accept) begin
            pt_mem[pt_wp]      <= in_data;
            pt_last_mem[pt_wp] <= in_last;
        end
        if (ks_push) ks_mem[ks_wp] <= core_block_i;
    end

endmodule
